// File: rtl/keccak_pkg.sv
// Shared definitions for the Keccak-f[200] round controller.
package keccak_pkg;

    localparam int unsigned NR_F200 = 18;
    localparam int unsigned LANE_W  = 8;
    localparam int unsigned RND_W   = 5;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_ROUND = 2'b01,
        ST_DONE  = 2'b10
    } ctrl_state_e;

    // An unroll factor is legal only if it splits the 18 rounds into whole iterations.
    function automatic bit unroll_legal(input int unsigned unroll);
        return (unroll != 0) && (unroll <= NR_F200) && ((NR_F200 % unroll) == 0);
    endfunction

endpackage

// File: rtl/keccak_roundconstant.sv
// Keccak-f[200] round constant lookup (low byte of the 64-bit Keccak constants).
module keccak_roundconstant
    import keccak_pkg::*;
(
    input  logic [RND_W-1:0]  round_nr_i,
    output logic [LANE_W-1:0] rc_o
);

    // Round number to constant; out-of-range rounds yield zero.
    always_comb begin
        rc_o = 8'h00;
        case (round_nr_i)
            5'd0:    rc_o = 8'h01;
            5'd1:    rc_o = 8'h82;
            5'd2:    rc_o = 8'h8A;
            5'd3:    rc_o = 8'h00;
            5'd4:    rc_o = 8'h8B;
            5'd5:    rc_o = 8'h01;
            5'd6:    rc_o = 8'h81;
            5'd7:    rc_o = 8'h09;
            5'd8:    rc_o = 8'h8A;
            5'd9:    rc_o = 8'h88;
            5'd10:   rc_o = 8'h09;
            5'd11:   rc_o = 8'h0A;
            5'd12:   rc_o = 8'h8B;
            5'd13:   rc_o = 8'h8B;
            5'd14:   rc_o = 8'h89;
            5'd15:   rc_o = 8'h03;
            5'd16:   rc_o = 8'h02;
            5'd17:   rc_o = 8'h80;
            default: rc_o = 8'h00;
        endcase
    end

endmodule

// File: rtl/keccak_round_ctrl.sv
// Round sequencer for an (optionally unrolled / multi-cycle) Keccak-f[200] datapath.
module keccak_round_ctrl
    import keccak_pkg::*;
#(
    parameter int unsigned NR     = 18,
    parameter int unsigned UNROLL = 1,
    parameter int unsigned STAGES = 1
) (
    input  logic                     ClkxCI,
    input  logic                     RstxRBI,
    input  logic                     InValidxSI,
    output logic                     InReadyxSO,
    input  logic                     AbortxSI,
    output logic                     OutValidxSO,
    input  logic                     OutReadyxSI,
    output logic                     LoadxSO,
    output logic                     StateEnxSO,
    output logic                     RandEnxSO,
    output logic [RND_W*UNROLL-1:0]  RoundNrxDO,
    output logic [LANE_W*UNROLL-1:0] RCxDO
);

    localparam int unsigned STG_W = (STAGES > 1) ? $clog2(STAGES) : 1;

    // Reject parameter sets the datapath cannot be sequenced with.
    if (!unroll_legal(UNROLL) || (NR != NR_F200) || (STAGES < 1)) begin : g_param_err
        $error("keccak_round_ctrl: illegal NR/UNROLL/STAGES combination");
    end

    ctrl_state_e      state_q, state_d;
    logic [RND_W-1:0] round_cnt_q, round_cnt_d;
    logic [STG_W-1:0] stage_cnt_q, stage_cnt_d;

    // State and counter registers.
    always_ff @(posedge ClkxCI or negedge RstxRBI) begin
        if (!RstxRBI) begin
            state_q     <= ST_IDLE;
            round_cnt_q <= '0;
            stage_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            round_cnt_q <= round_cnt_d;
            stage_cnt_q <= stage_cnt_d;
        end
    end

    // Next-state, counter update and handshake/enable decode; abort overrides everything.
    always_comb begin
        state_d     = state_q;
        round_cnt_d = round_cnt_q;
        stage_cnt_d = stage_cnt_q;
        InReadyxSO  = 1'b0;
        LoadxSO     = 1'b0;
        StateEnxSO  = 1'b0;
        RandEnxSO   = 1'b0;
        OutValidxSO = (state_q == ST_DONE);

        if (AbortxSI) begin
            state_d     = ST_IDLE;
            round_cnt_d = '0;
            stage_cnt_d = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    InReadyxSO = 1'b1;
                    if (InValidxSI) begin
                        LoadxSO     = 1'b1;
                        StateEnxSO  = 1'b1;
                        state_d     = ST_ROUND;
                        round_cnt_d = '0;
                        stage_cnt_d = '0;
                    end
                end
                ST_ROUND: begin
                    RandEnxSO = 1'b1;
                    if (stage_cnt_q == STG_W'(STAGES - 1)) begin
                        StateEnxSO  = 1'b1;
                        stage_cnt_d = '0;
                        if (round_cnt_q == RND_W'(NR - UNROLL)) begin
                            state_d     = ST_DONE;
                            round_cnt_d = '0;
                        end else begin
                            round_cnt_d = round_cnt_q + RND_W'(UNROLL);
                        end
                    end else begin
                        stage_cnt_d = stage_cnt_q + STG_W'(1);
                    end
                end
                ST_DONE: begin
                    if (OutReadyxSI) begin
                        state_d = ST_IDLE;
                    end
                end
                default: begin
                    state_d     = ST_IDLE;
                    round_cnt_d = '0;
                    stage_cnt_d = '0;
                end
            endcase
        end
    end

    // Per-lane round numbers (zero outside ROUND) and their constants.
    for (genvar u = 0; u < int'(UNROLL); u++) begin : g_lane
        assign RoundNrxDO[RND_W*u +: RND_W] = (state_q == ST_ROUND) ?
                                               round_cnt_q + RND_W'(u) : '0;
        keccak_roundconstant u_rc (
            .round_nr_i (RoundNrxDO[RND_W*u +: RND_W]),
            .rc_o       (RCxDO[LANE_W*u +: LANE_W])
        );
    end

endmodule

// File: doc/keccak_round_ctrl.md
Name: keccak_round_ctrl

Overview:
Sequencer for the Keccak-f[200] permutation datapath (8-bit lanes, 18 rounds). It accepts a state load over a valid/ready handshake and steps a round counter through the permutation. It generates the per-iteration round numbers and round constants, plus the state-register and randomness-refresh enables. It supports unrolled (several rounds per iteration) and pipelined/masked (several cycles per iteration) datapaths, and presents the finished state over an output valid/ready handshake.

Parameters:
NR, 18, number of rounds; fixed to 18 for the 8-bit lane width.
UNROLL, 1, rounds computed per iteration; must divide NR (legal values 1, 2, 3, 6, 9, 18); elaboration error otherwise.
STAGES, 1, clock cycles per iteration (register stages in the masked round); must be at least 1.

Ports:
ClkxCI  in  1  clock; all state changes on the rising edge.
RstxRBI  in  1  asynchronous active-low reset.
InValidxSI  in  1  input state valid.
InReadyxSO  out  1  controller idle and able to accept a state.
AbortxSI  in  1  synchronous abort; returns the controller to IDLE.
OutValidxSO  out  1  permutation result valid.
OutReadyxSI  in  1  consumer accepts the result.
LoadxSO  out  1  state mux selects external input (1) or round output (0).
StateEnxSO  out  1  state register write enable.
RandEnxSO  out  1  fresh-randomness register update enable.
RoundNrxDO  out  5*UNROLL  round number per unrolled lane; lane u = RoundCnt+u.
RCxDO  out  8*UNROLL  round constant per unrolled lane; lane u occupies bits [8u+7:8u].

Behaviour:
- Reset: FSM in IDLE, RoundCnt=0, StageCnt=0. Outputs: InReadyxSO=1, OutValidxSO=0, LoadxSO=0, StateEnxSO=0, RandEnxSO=0, RoundNrxDO=0, RCxDO lane 0 = 0x01.
- FSM has three states: IDLE, ROUND, DONE. All outputs are decoded combinationally from state, counters and inputs.
- IDLE:
  - InReadyxSO=1.
  - When InValidxSI=1, LoadxSO=1 and StateEnxSO=1 in the same cycle.
  - Next state ROUND; RoundCnt=0, StageCnt=0.
- ROUND:
  - RandEnxSO=1 every cycle; LoadxSO=0.
  - StageCnt counts 0..STAGES-1 and wraps to 0.
  - StateEnxSO=1 only when StageCnt=STAGES-1.
  - At that cycle RoundCnt += UNROLL. If RoundCnt+UNROLL=NR, go to DONE and clear RoundCnt to 0.
- DONE:
  - OutValidxSO=1; it is held stable, with no enables, until OutReadyxSI=1.
  - On OutReadyxSI=1, go to IDLE. InReadyxSO stays 0 throughout DONE; there is no same-cycle reload.
- Latency: the edge that accepts the input is edge 0. OutValidxSO rises after edge (NR/UNROLL)*STAGES, i.e. 18 edges with default parameters.
- RoundNrxDO/RCxDO: equal RoundCnt+u and its constant while in ROUND, and are stable for the full STAGES cycles of an iteration. They are 0 / 0x01 (lane 0) outside ROUND.
- AbortxSI: highest priority below reset. From any state it forces next state IDLE and clears both counters. In the abort cycle StateEnxSO, LoadxSO and RandEnxSO are 0, and InReadyxSO=0 even if in IDLE.
- Asynchronous reset mid-operation immediately returns to the reset values; no partial result is ever signalled.
- RoundCnt width is 5 bits and never exceeds NR-UNROLL; no wrap beyond NR.

Decomposition:
- Shared package keccak_pkg holds:
  - NR_F200=18 and LANE_W=8.
  - The FSM state encoding (IDLE=2'b00, ROUND=2'b01, DONE=2'b10).
  - The UNROLL legality check function.
- One sub-module: keccak_roundconstant, instantiated UNROLL times in a generate loop. Each instance is fed RoundNrxDO lane u and drives RCxDO lane u.

Test Plan:
1. Defaults, InValid pulse at edge 0 → RCxDO over the 18 ROUND cycles = 01,82,8A,00,8B,01,81,09,8A,88,09,0A,8B,8B,89,03,02,80; StateEn high every ROUND cycle; OutValid after edge 18.
2. UNROLL=2 → 9 iterations. RCxDO = {82,01}, {00,8A}, …, {80,02}; RoundNrxDO lanes = (0,1)…(16,17); OutValid after edge 9.
3. STAGES=3 → each RC held 3 cycles; StateEn pulses on every third cycle; RandEn continuous; OutValid after edge 54.
4. Backpressure: OutReadyxSI low 5 cycles in DONE → OutValid held; InReady=0 and no enables; OutReady=1 → IDLE next edge with InReady=1.
5. AbortxSI asserted at RoundCnt=7 → IDLE next edge; RoundNr=0; new load then yields the full 18-constant sequence from 0x01.
6. RstxRBI low mid-ROUND (RoundCnt=11) → outputs go immediately to reset values; after release, InReady=1 and OutValid stays 0.
